// File: rtl/prog_interval_timer.sv
// prog_interval_timer
// Programmable interval timer built on a base-tick prescaler. A start with a
// non-zero interval loads the period and launches the timer; every TICK_DIV
// enabled clocks one base tick is taken off the remaining count, and timeout
// pulses when the count runs out. One-shot mode returns to IDLE at expiry;
// periodic mode reloads the latched interval and keeps running.
//
// Ports
//   clk_i        single clock, rising edge
//   rst_ni       asynchronous active-low reset
//   enable_i     high = count, low = freeze prescaler and remaining
//   start_i      load/launch request (ignored when interval_i == 0)
//   stop_i       abort request, wins over start and expiry
//   periodic_i   mode select (0 one-shot, 1 auto-reload), latched on start
//   interval_i   period in base ticks, latched on start
//   timeout_o    one-cycle pulse at interval expiry
//   busy_o       high while in RUN
//   remaining_o  base ticks left in the current period
//   tick_o       one-cycle pulse per base tick while running and enabled
//
// state | meaning
// IDLE  | stopped, remaining = 0, waiting for an accepted start
// RUN   | prescaler counting, remaining decrements once per base tick
module prog_interval_timer #(
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             periodic_i,
   input  logic [CNT_W-1:0] interval_i,
   output logic             timeout_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] remaining_o,
   output logic             tick_o
);

   localparam int unsigned   PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q,     state_d;
   logic [PW-1:0]    presc_q,     presc_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] ivl_q,       ivl_d;
   logic             per_q,       per_d;
   logic             timeout_q,   timeout_d;
   logic             tick_q,      tick_d;

   logic accept;
   assign accept = start_i && !stop_i && (interval_i != '0);

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      remaining_d = remaining_q;
      ivl_d       = ivl_q;
      per_d       = per_q;
      timeout_d   = 1'b0;
      tick_d      = 1'b0;

      if (stop_i) begin
         state_d     = IDLE;
         presc_d     = '0;
         remaining_d = '0;
      end else if (accept) begin
         // A restart also swallows any tick/expiry falling on this edge.
         state_d     = RUN;
         presc_d     = '0;
         remaining_d = interval_i;
         ivl_d       = interval_i;
         per_d       = periodic_i;
      end else if (state_q == RUN && enable_i) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (remaining_q <= CNT_W'(1)) begin
               timeout_d = 1'b1;
               if (per_q) begin
                  remaining_d = ivl_q;
               end else begin
                  remaining_d = '0;
                  state_d     = IDLE;
               end
            end else begin
               remaining_d = remaining_q - CNT_W'(1);
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         remaining_q <= '0;
         ivl_q       <= '0;
         per_q       <= 1'b0;
         timeout_q   <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         remaining_q <= remaining_d;
         ivl_q       <= ivl_d;
         per_q       <= per_d;
         timeout_q   <= timeout_d;
         tick_q      <= tick_d;
      end
   end

   assign timeout_o   = timeout_q;
   assign tick_o      = tick_q;
   assign remaining_o = remaining_q;
   assign busy_o      = (state_q == RUN);

endmodule

// File: tb/tb_prog_interval_timer.sv
// Bench for prog_interval_timer with TICK_DIV=4, CNT_W=8.
// Stimulus pushes the cycle index at which each timeout is due; a monitor
// pops one entry per observed timeout pulse and compares cycle indices.
module tb_prog_interval_timer;

   localparam int TD = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable, start, stop, periodic;
   logic [CW-1:0] interval;
   logic          timeout, busy, tick;
   logic [CW-1:0] remaining;

   int cyc      = 0;
   int tick_cnt = 0;
   int n_tests  = 0;
   int n_fail   = 0;
   int exp_q[$];

   prog_interval_timer #(.TICK_DIV(TD), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .start_i(start),
      .stop_i(stop), .periodic_i(periodic), .interval_i(interval),
      .timeout_o(timeout), .busy_o(busy), .remaining_o(remaining), .tick_o(tick)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: each timeout pulse must match the oldest scheduled expiry.
   always @(negedge clk) begin
      if (rst_n) begin
         if (tick) tick_cnt++;
         if (timeout) begin
            if (exp_q.size() == 0) chk("unexpected_timeout", cyc, -1);
            else chk("timeout_cycle", cyc, exp_q.pop_front());
         end
      end
   end

   // Called at a negedge; drives a start for one edge, returns E0.
   task automatic do_start(input int iv, input logic per, output int e0);
      start = 1'b1; interval = CW'(iv); periodic = per;
      @(negedge clk);
      e0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int e0, e1, tk0;
      rst_n = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0;
      periodic = 1'b0; interval = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_tick", tick, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_rst", busy, 0);

      // One-shot, interval 3: timeout after E0+12.
      do_start(3, 1'b0, e0);
      exp_q.push_back(e0 + 12);
      chk("os_busy_start", busy, 1);
      chk("os_rem_start", remaining, 3);
      wait_until(e0 + 11);
      chk("os_busy_before", busy, 1);
      chk("os_rem_before", remaining, 1);
      wait_until(e0 + 12);
      chk("os_busy_expiry", busy, 0);
      chk("os_rem_expiry", remaining, 0);
      wait_until(e0 + 16);

      // Periodic, interval 2: timeouts every 8 cycles, tick every 4.
      do_start(2, 1'b1, e0);
      tk0 = tick_cnt;
      for (int k = 1; k <= 5; k++) exp_q.push_back(e0 + 8 * k);
      wait_until(e0 + 41);
      chk("per_busy", busy, 1);
      chk("per_ticks", tick_cnt - tk0, 10);
      chk("per_rem", remaining, 2);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("per_stop_busy", busy, 0);
      chk("per_stop_rem", remaining, 0);
      repeat (10) @(negedge clk);

      // Enable low for 5 edges: one-shot interval 2 expires after E0+13.
      do_start(2, 1'b0, e0);
      exp_q.push_back(e0 + 13);
      wait_until(e0 + 2);
      enable = 1'b0;
      wait_until(e0 + 7);
      chk("gap_rem_frozen", remaining, 2);
      chk("gap_busy", busy, 1);
      enable = 1'b1;
      wait_until(e0 + 9);
      chk("gap_rem_after", remaining, 1);
      wait_until(e0 + 16);
      chk("gap_busy_end", busy, 0);

      // Stop on the expiry edge.
      do_start(1, 1'b0, e0);
      wait_until(e0 + 3);
      stop = 1'b1;
      wait_until(e0 + 4);
      stop = 1'b0;
      chk("stopexp_busy", busy, 0);
      chk("stopexp_rem", remaining, 0);
      chk("stopexp_timeout", timeout, 0);
      wait_until(e0 + 8);

      // Start and stop together while running: stop wins.
      do_start(5, 1'b0, e0);
      start = 1'b1; stop = 1'b1; interval = 8'd7;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("startstop_busy", busy, 0);
      chk("startstop_rem", remaining, 0);

      // Start with interval 0 in IDLE is ignored.
      tk0 = tick_cnt;
      start = 1'b1; interval = '0;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("zero_busy", busy, 0);
      chk("zero_ticks", tick_cnt - tk0, 0);

      // Restart at remaining=1 with interval 5: next timeout 20 cycles on.
      do_start(2, 1'b0, e0);
      wait_until(e0 + 5);
      chk("rs_rem_one", remaining, 1);
      do_start(5, 1'b0, e1);
      exp_q.push_back(e1 + 20);
      chk("rs_rem_load", remaining, 5);
      interval = 8'd1; periodic = 1'b1;
      wait_until(e1 + 3);
      start = 1'b1; interval = '0;
      @(negedge clk);
      start = 1'b0; interval = 8'd1;
      chk("rs_zero_in_run_busy", busy, 1);
      chk("rs_zero_in_run_rem", remaining, 4);
      wait_until(e1 + 21);
      chk("rs_oneshot_kept", busy, 0);

      // Asynchronous reset mid-run, right after a tick.
      do_start(3, 1'b1, e0);
      wait_until(e0 + 4);
      chk("ar_tick_pre", tick, 1);
      chk("ar_rem_pre", remaining, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_rem", remaining, 0);
      chk("ar_tick", tick, 0);
      chk("ar_timeout", timeout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("ar_idle_after", busy, 0);

      chk("pending_timeouts", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_interval_timer.md
PROG_INTERVAL_TIMER -- requirements
Module: prog_interval_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set the clock cycles per base tick (1 ms at 50 MHz); legal range 2..2^24.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the interval and remaining-count fields; legal range 1..32.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL gate counting: high = count, low = freeze prescaler and remaining.
REQ-006 start  input  1  SHALL be a load/launch request, sampled every edge.
REQ-007 stop  input  1  SHALL be an abort request, sampled every edge.
REQ-008 periodic  input  1  SHALL select the mode (0 one-shot, 1 auto-reload), sampled only on an accepted start.
REQ-009 interval  input  CNT_W  SHALL give the period in base ticks, sampled only on an accepted start.
REQ-010 timeout  output  1  SHALL be a registered one-cycle pulse at interval expiry.
REQ-011 busy  output  1  SHALL be high while in state RUN.
REQ-012 remaining  output  CNT_W  SHALL show the base ticks left in the current period (registered).
REQ-013 tick  output  1  SHALL be a registered one-cycle pulse per base tick while in RUN and enable is high.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN.
REQ-015 An accepted start is start=1, stop=0, interval!=0; it SHALL load remaining<=interval, latch interval and periodic, clear the prescaler to 0 and enter RUN, from either state.
REQ-016 start with interval==0 SHALL be ignored (no state, counter or output change).
REQ-017 stop=1 SHALL enter IDLE, clear remaining and prescaler, and suppress any timeout for that edge; stop SHALL win over start and over a coincident expiry.
REQ-018 In RUN with enable=1 the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; the wrapping edge is a tick edge.
REQ-019 On a tick edge remaining SHALL decrement by 1, and tick SHALL be high for the following cycle.
REQ-020 A tick edge with remaining==1 is expiry: timeout SHALL be high for exactly the following cycle.
REQ-021 At expiry in one-shot mode the FSM SHALL enter IDLE, remaining SHALL become 0 and busy SHALL fall in the same cycle timeout rises.
REQ-022 At expiry in periodic mode remaining SHALL reload from the latched interval and the FSM SHALL stay in RUN with no lost cycles.
REQ-023 With enable=0 the prescaler, remaining, tick and timeout SHALL hold/stay low; start and stop SHALL still be honoured.
REQ-024 Latency: after an accepted start at edge E0 with continuous enable, the first timeout SHALL be high in the cycle after edge E0+N*TICK_DIV (N = interval); periodic repeats SHALL occur every N*TICK_DIV cycles.
REQ-025 Changes to interval or periodic while in RUN SHALL have no effect until the next accepted start.
REQ-026 An accepted start while in RUN, including on an expiry edge, SHALL restart the period and suppress that edge's timeout.
REQ-027 The prescaler width SHALL be $clog2(TICK_DIV); remaining SHALL never underflow below 0.

Reset
REQ-028 While rst=0 the block SHALL be in IDLE with timeout=0, busy=0, tick=0, remaining=0, prescaler=0, latched interval=0, latched periodic=0.
REQ-029 After rst rises, the block SHALL stay in IDLE until the first accepted start; reset mid-RUN SHALL abort without a timeout.

Verification (TICK_DIV=4, CNT_W=8)
REQ-030 One-shot: start, interval=3, periodic=0 -> timeout high only in the cycle after edge E0+12; busy low from that cycle; remaining=0.
REQ-031 Periodic: interval=2, periodic=1, 40 cycles -> timeout after E0+8, +16, +24, +32, +40; busy stays 1; a tick every 4 cycles.
REQ-032 Enable gap: one-shot interval=2, enable low for 5 cycles mid-run -> timeout delayed by exactly 5 cycles (after E0+13).
REQ-033 Stop on the expiry edge -> no timeout, IDLE, remaining=0; start+stop on the same edge -> IDLE.
REQ-034 start with interval=0 in IDLE -> busy stays 0, no tick, no timeout; restart at remaining=1 with interval=5 -> remaining=5 and next timeout 20 cycles later.
REQ-035 rst low mid-RUN -> all outputs 0 immediately (asynchronously); no timeout after release.
